// File: rtl/pixel_addr_gen.sv
// Raster-order pixel read address generator for a 3x3 window filter.
// Optional write-address channel: define PIXEL_ADDR_GEN_WRADDR_EN.
module pixel_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DIM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIM_WIDTH-1:0]  width,
  input  logic [DIM_WIDTH-1:0]  height,
  input  logic [ADDR_WIDTH-1:0] read_base,
  input  logic [ADDR_WIDTH-1:0] write_base,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_ack,
  output logic [DIM_WIDTH-1:0]  row_idx,
  output logic [DIM_WIDTH-1:0]  col_idx,
  output logic                  busy,
  output logic                  done,
`ifdef PIXEL_ADDR_GEN_WRADDR_EN
  output logic                  cfg_err,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr
`else
  output logic                  cfg_err
`endif
);

  localparam int unsigned MIN_DIM = 3;
  localparam int unsigned WIN_EDGE = MIN_DIM - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [DIM_WIDTH-1:0]  r_width;
  logic [DIM_WIDTH-1:0]  r_height;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DIM_WIDTH-1:0]  r_row;
  logic [DIM_WIDTH-1:0]  r_col;
  logic                  r_rd_req;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cfg_err;
  logic                  r_wr_valid;
  logic [ADDR_WIDTH-1:0] r_wr_addr;

  logic w_cfg_ok;
  logic w_col_last;
  logic w_row_last;
  logic w_window;

  assign w_cfg_ok   = (width >= DIM_WIDTH'(MIN_DIM)) && (height >= DIM_WIDTH'(MIN_DIM));
  assign w_col_last = (r_col == r_width  - DIM_WIDTH'(1));
  assign w_row_last = (r_row == r_height - DIM_WIDTH'(1));
  // A 3x3 window is complete once the pixel at its bottom-right corner is read.
  assign w_window   = (r_row >= DIM_WIDTH'(WIN_EDGE)) && (r_col >= DIM_WIDTH'(WIN_EDGE));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_width    <= '0;
      r_height   <= '0;
      r_addr     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_rd_req   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
    end else begin
      r_cfg_err  <= 1'b0;
      r_done     <= 1'b0;
      r_wr_valid <= 1'b0;
      // Output write address advances once per emitted result.
      if (r_wr_valid) begin
        r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_width   <= width;
              r_height  <= height;
              r_addr    <= read_base;
              r_row     <= '0;
              r_col     <= '0;
              r_wr_addr <= write_base;
              r_rd_req  <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= S_RUN;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_rd_req <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (rd_ack) begin
            r_addr     <= r_addr + ADDR_WIDTH'(1);
            r_wr_valid <= w_window;
            if (w_col_last && w_row_last) begin
              r_rd_req <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else if (w_col_last) begin
              r_col <= '0;
              r_row <= r_row + DIM_WIDTH'(1);
            end else begin
              r_col <= r_col + DIM_WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          r_rd_req <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_rd_req <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_req  = r_rd_req;
  assign rd_addr = r_addr;
  assign row_idx = r_row;
  assign col_idx = r_col;
  assign busy    = r_busy;
  assign done    = r_done;
  assign cfg_err = r_cfg_err;

`ifdef PIXEL_ADDR_GEN_WRADDR_EN
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
`else
  // Write channel absent: fold its state into a sink so nothing dangles.
  logic w_unused;
  assign w_unused = r_wr_valid ^ (^r_wr_addr);
`endif

endmodule

// File: tb/tb_pixel_addr_gen.sv
// Scoreboard bench for pixel_addr_gen: expected pixels queued at start, popped on each ack.
module tb_pixel_addr_gen;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] row;
    logic [DW-1:0] col;
  } pix_t;

  logic          clk;
  logic          n_rst;
  logic          start;
  logic          abort;
  logic [DW-1:0] width;
  logic [DW-1:0] height;
  logic [AW-1:0] read_base;
  logic [AW-1:0] write_base;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] row_idx;
  logic [DW-1:0] col_idx;
  logic          busy;
  logic          done;
  logic          cfg_err;
`ifdef PIXEL_ADDR_GEN_WRADDR_EN
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
`endif

  pix_t          exp_q[$];
  logic [AW-1:0] wr_q[$];
  int            n_pass;
  int            n_total;

  pixel_addr_gen #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .abort      (abort),
    .width      (width),
    .height     (height),
    .read_base  (read_base),
    .write_base (write_base),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .busy       (busy),
    .done       (done),
`ifdef PIXEL_ADDR_GEN_WRADDR_EN
    .cfg_err    (cfg_err),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr)
`else
    .cfg_err    (cfg_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_frame(input int w, input int h, input logic [AW-1:0] base);
    logic [AW-1:0] a;
    a = base;
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        exp_q.push_back('{addr: a, row: DW'(r), col: DW'(c)});
        a = a + AW'(1);
      end
    end
  endfunction

  task automatic kick(input int w, input int h, input logic [AW-1:0] base);
    width     = DW'(w);
    height    = DW'(h);
    read_base = base;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; rd_ack = 1'b0;
    width = '0; height = '0; read_base = '0; write_base = '0;
    #12;
    n_total++;
    if ({rd_req, rd_addr, row_idx, col_idx, busy, done, cfg_err} !== '0) begin
      $display("FAIL reset_outputs: rd_req=%0b rd_addr=%h row=%0d col=%0d busy=%0b done=%0b cfg_err=%0b, want all zero",
               rd_req, rd_addr, row_idx, col_idx, busy, done, cfg_err);
    end else n_pass++;
    step();
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_basic_frame();
    pix_t e;
    push_frame(4, 3, 32'h1000);
    kick(4, 3, 32'h1000);
    // Inputs change after acceptance; the frame must not notice.
    width = 16'd1; height = 16'd1; read_base = 32'hDEAD_0000;
    rd_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      e = exp_q.pop_front();
      n_total++;
      if ({rd_req, rd_addr, row_idx, col_idx, cfg_err, done, busy} !== {1'b1, e.addr, e.row, e.col, 1'b0, 1'b0, 1'b1}) begin
        $display("FAIL basic_pixel%0d: req=%0b addr=%h row=%0d col=%0d err=%0b done=%0b, want req=1 addr=%h row=%0d col=%0d err=0 done=0",
                 i, rd_req, rd_addr, row_idx, col_idx, cfg_err, done, e.addr, e.row, e.col);
      end else n_pass++;
      start = (i == 5);
      step();
    end
    start = 1'b0;
    n_total++;
    if ({done, busy, rd_req} !== 3'b110) begin
      $display("FAIL basic_done: done=%0b busy=%0b rd_req=%0b, want 1 1 0", done, busy, rd_req);
    end else n_pass++;
    step();
    n_total++;
    if ({done, busy, rd_req, cfg_err} !== 4'b0000) begin
      $display("FAIL basic_idle: done=%0b busy=%0b rd_req=%0b cfg_err=%0b, want 0 0 0 0", done, busy, rd_req, cfg_err);
    end else n_pass++;
    rd_ack = 1'b0;
    step();
  endtask

  task automatic test_bad_cfg();
    int ws[2] = '{2, 5};
    int hs[2] = '{5, 2};
    for (int k = 0; k < 2; k++) begin
      kick(ws[k], hs[k], 32'h7000);
      n_total++;
      if ({cfg_err, busy, rd_req} !== 3'b100) begin
        $display("FAIL bad_cfg%0d_pulse: cfg_err=%0b busy=%0b rd_req=%0b, want 1 0 0", k, cfg_err, busy, rd_req);
      end else n_pass++;
      step();
      n_total++;
      if ({cfg_err, busy, rd_req} !== 3'b000) begin
        $display("FAIL bad_cfg%0d_after: cfg_err=%0b busy=%0b rd_req=%0b, want 0 0 0", k, cfg_err, busy, rd_req);
      end else n_pass++;
    end
  endtask

  task automatic test_stall();
    pix_t e;
    push_frame(4, 3, 32'h500);
    kick(4, 3, 32'h500);
    for (int i = 0; i < 12; i++) begin
      e = exp_q.pop_front();
      if (e.row == 1 && e.col == 2) begin
        rd_ack = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          n_total++;
          if ({rd_req, rd_addr, row_idx, col_idx} !== {1'b1, e.addr, e.row, e.col}) begin
            $display("FAIL stall_hold%0d: req=%0b addr=%h row=%0d col=%0d, want req=1 addr=%h row=1 col=2",
                     s, rd_req, rd_addr, row_idx, col_idx, e.addr);
          end else n_pass++;
        end
      end
      rd_ack = 1'b1;
      n_total++;
      if ({rd_req, rd_addr, row_idx, col_idx} !== {1'b1, e.addr, e.row, e.col}) begin
        $display("FAIL stall_pixel%0d: addr=%h row=%0d col=%0d, want addr=%h row=%0d col=%0d",
                 i, rd_addr, row_idx, col_idx, e.addr, e.row, e.col);
      end else n_pass++;
      step();
    end
    rd_ack = 1'b0;
    n_total++;
    if (done !== 1'b1) begin
      $display("FAIL stall_done: done=%0b, want 1", done);
    end else n_pass++;
    step();
  endtask

  task automatic test_abort();
    pix_t e;
    kick(4, 3, 32'h300);
    rd_ack = 1'b1;
    step();
    n_total++;
    if ({rd_addr, row_idx, col_idx} !== {32'h301, 16'd0, 16'd1}) begin
      $display("FAIL abort_pre: addr=%h row=%0d col=%0d, want addr=301 row=0 col=1", rd_addr, row_idx, col_idx);
    end else n_pass++;
    abort = 1'b1;
    step();
    abort = 1'b0; rd_ack = 1'b0;
    n_total++;
    if ({busy, rd_req, done} !== 3'b000) begin
      $display("FAIL abort_idle: busy=%0b rd_req=%0b done=%0b, want 0 0 0", busy, rd_req, done);
    end else n_pass++;
    step();
    n_total++;
    if ({busy, done} !== 2'b00) begin
      $display("FAIL abort_no_done: busy=%0b done=%0b, want 0 0", busy, done);
    end else n_pass++;
    push_frame(4, 3, 32'h300);
    kick(4, 3, 32'h300);
    rd_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      e = exp_q.pop_front();
      n_total++;
      if ({rd_req, rd_addr, row_idx, col_idx} !== {1'b1, e.addr, e.row, e.col}) begin
        $display("FAIL restart_pixel%0d: addr=%h row=%0d col=%0d, want addr=%h row=%0d col=%0d",
                 i, rd_addr, row_idx, col_idx, e.addr, e.row, e.col);
      end else n_pass++;
      step();
    end
    rd_ack = 1'b0;
    n_total++;
    if (done !== 1'b1) begin
      $display("FAIL restart_done: done=%0b, want 1", done);
    end else n_pass++;
    step();
  endtask

  task automatic test_reset_midframe();
    kick(3, 3, 32'h40);
    rd_ack = 1'b1;
    step();
    step();
    #2;
    n_rst = 1'b0;
    #1;
    n_total++;
    if ({busy, rd_req, rd_addr, row_idx, col_idx, done} !== '0) begin
      $display("FAIL async_reset: busy=%0b req=%0b addr=%h row=%0d col=%0d done=%0b, want all zero",
               busy, rd_req, rd_addr, row_idx, col_idx, done);
    end else n_pass++;
    rd_ack = 1'b0;
    step();
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_addr_wrap();
    pix_t e;
    push_frame(3, 3, 32'hFFFF_FFFE);
    kick(3, 3, 32'hFFFF_FFFE);
    rd_ack = 1'b1;
    for (int i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      n_total++;
      if ({rd_req, rd_addr, row_idx, col_idx} !== {1'b1, e.addr, e.row, e.col}) begin
        $display("FAIL wrap_pixel%0d: addr=%h row=%0d col=%0d, want addr=%h row=%0d col=%0d",
                 i, rd_addr, row_idx, col_idx, e.addr, e.row, e.col);
      end else n_pass++;
      step();
    end
    rd_ack = 1'b0;
    n_total++;
    if ({done, rd_addr} !== {1'b1, 32'h0000_0007}) begin
      $display("FAIL wrap_done: done=%0b addr=%h, want done=1 addr=00000007", done, rd_addr);
    end else n_pass++;
    step();
  endtask

`ifdef PIXEL_ADDR_GEN_WRADDR_EN
  task automatic test_wr_channel();
    pix_t e;
    logic [AW-1:0] nxt;
    logic [AW-1:0] w;
    int seen;
    seen = 0;
    nxt = 32'h2000;
    wr_q.delete();
    write_base = 32'h2000;
    push_frame(4, 4, 32'h0);
    kick(4, 4, 32'h0);
    rd_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      if (e.row >= 2 && e.col >= 2) begin
        wr_q.push_back(nxt);
        nxt = nxt + AW'(1);
      end
      step();
      if (wr_valid === 1'b1) begin
        seen++;
        n_total++;
        if (wr_q.size() == 0) begin
          $display("FAIL wr_unexpected: wr_valid after pixel (%0d,%0d) addr=%h", e.row, e.col, wr_addr);
        end else begin
          w = wr_q.pop_front();
          if (wr_addr !== w) begin
            $display("FAIL wr_addr: got %h after pixel (%0d,%0d), want %h", wr_addr, e.row, e.col, w);
          end else n_pass++;
        end
      end
    end
    rd_ack = 1'b0;
    n_total++;
    if (seen != 4 || wr_q.size() != 0) begin
      $display("FAIL wr_count: saw %0d pulses, want 4", seen);
    end else n_pass++;
    step();
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_basic_frame();
    test_bad_cfg();
    test_stall();
    test_abort();
    test_reset_midframe();
    test_addr_wrap();
`ifdef PIXEL_ADDR_GEN_WRADDR_EN
    test_wr_channel();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pixel_addr_gen.md
PIXEL_ADDR_GEN -- requirements
Module: pixel_addr_gen

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the bus address width.
REQ-002 Parameter DIM_WIDTH, default 16, SHALL set the width/height field width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 n_rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle kickstart pulse from the initializer.
REQ-006 abort  input  1  SHALL be a synchronous request to cancel a running frame.
REQ-007 width, height  input  DIM_WIDTH each  SHALL give image dimensions in pixels, sampled on accepted start.
REQ-008 read_base  input  ADDR_WIDTH  SHALL give the source image byte address, sampled on accepted start.
REQ-009 write_base  input  ADDR_WIDTH  SHALL give the result image byte address, sampled on accepted start.
REQ-010 rd_req  output  1  SHALL be the pixel read request to the bus master.
REQ-011 rd_addr  output  ADDR_WIDTH  SHALL be the byte address of the requested pixel.
REQ-012 rd_ack  input  1  SHALL be the bus master's completion strobe for the current read.
REQ-013 row_idx, col_idx  output  DIM_WIDTH each  SHALL give the coordinates of the pixel on rd_addr.
REQ-014 busy  output  1  SHALL be high while not IDLE.
REQ-015 done  output  1  SHALL pulse one cycle when a frame completes.
REQ-016 cfg_err  output  1  SHALL pulse one cycle when start is rejected.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DONE.
- IDLE: start with width>=3 and height>=3 -> latch config, rd_addr=read_base, row/col=0, go RUN.
- IDLE: start with width<3 or height<3 -> cfg_err=1 next cycle, stay IDLE.
- RUN -> DONE on rd_ack for pixel (height-1, width-1).
- DONE -> IDLE after one cycle; done=1 during DONE.
REQ-018 In RUN, rd_req SHALL be 1 and rd_addr/row_idx/col_idx SHALL stay stable until rd_ack.
REQ-019 On rd_ack in RUN, rd_addr SHALL increment by 1 (8-bit pixels, raster order, modulo 2^ADDR_WIDTH), with no multiplier.
REQ-020 On rd_ack with col_idx==width-1, col_idx SHALL wrap to 0 and row_idx SHALL increment; otherwise col_idx increments.
REQ-021 Read latency SHALL be zero: the next address appears the cycle after rd_ack; back-to-back acks every cycle SHALL be sustained.
REQ-022 start outside IDLE SHALL be ignored, with no cfg_err and no change to the latched config.
REQ-023 rd_ack outside RUN SHALL be ignored.
REQ-024 abort in RUN or DONE SHALL force IDLE next cycle, with rd_req=0 and no done pulse; abort wins over a simultaneous rd_ack.
REQ-025 width/height/base changes after an accepted start SHALL not affect the running frame.

Reset
REQ-026 While n_rst=0, the block SHALL be in IDLE with rd_req=0, rd_addr=0, row_idx=0, col_idx=0, busy=0, done=0, cfg_err=0, and all latched config=0.
REQ-027 A reset assertion mid-frame SHALL take effect immediately, independent of clk.
REQ-028 After reset release, the first accepted start SHALL run a frame identical to one from a fresh power-up.

Configuration
REQ-029 Macro PIXEL_ADDR_GEN_WRADDR_EN SHALL control the write-address channel.
- Defined: ports wr_valid (output 1) and wr_addr (output ADDR_WIDTH) exist.
- wr_valid pulses on each rd_ack where row_idx>=2 and col_idx>=2 (3x3 window complete).
- wr_addr starts at write_base and increments by 1 after each wr_valid.
- The result is a (width-2)x(height-2) output frame.
- Not defined: the ports are absent and write_base is unused.

Verification
REQ-030 Basic frame: width=4, height=3, read_base=0x1000, ack every cycle -> rd_addr 0x1000..0x100B, 12 acks, done one cycle after the last ack.
REQ-031 Bad config: start with width=2, height=5 -> cfg_err pulse, busy stays 0, rd_req stays 0.
REQ-032 Ack stall: hold rd_ack=0 for 5 cycles at pixel (1,2) -> rd_addr, row_idx, col_idx stable, rd_req=1 throughout.
REQ-033 Abort: abort together with rd_ack at pixel (0,1) -> IDLE next cycle, no done; a new start restarts at read_base.
REQ-034 Address wrap: read_base=0xFFFFFFFE, width=3, height=3 -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 ... 0x00000006.
REQ-035 With PIXEL_ADDR_GEN_WRADDR_EN, width=4, height=4, write_base=0x2000 -> 4 wr_valid pulses at pixels (2,2), (2,3), (3,2), (3,3), with wr_addr 0x2000..0x2003.
